c_dlatch_bank_ctrl: RTL and testbench

- Write scheduler and arbiter for a bank of binary D latches built from the NOR-latch cells.
- Each latch word takes a level-sensitive enable (its "clock") and a data bus.
- Two requesters share the bank through a round-robin grant. For each write the controller runs a glitch-safe sequence: data setup, enable open, data hold.
- The controller also provides a combinational readback mux of the latch Q outputs.

---
 rtl/c_dlatch_bank_ctrl.sv | 131 +++++++++++++
 tb/tb_c_dlatch_bank_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/c_dlatch_bank_ctrl.sv
// Write scheduler for a bank of level-sensitive D-latch words: round-robin grant
// between two requesters, setup/open/hold enable sequencing and a readback mux.
module c_dlatch_bank_ctrl #(
  parameter int WIDTH    = 2,
  parameter int WORDS    = 4,
  parameter int AW       = 2,
  parameter int OPEN_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic [AW-1:0]          addr0,
  input  logic [WIDTH-1:0]       data0,
  output logic                   gnt0,
  output logic                   done0,
  input  logic                   req1,
  input  logic [AW-1:0]          addr1,
  input  logic [WIDTH-1:0]       data1,
  output logic                   gnt1,
  output logic                   done1,
  output logic                   err,
  output logic                   busy,
  output logic [WIDTH-1:0]       lat_d,
  output logic [WORDS-1:0]       lat_en,
  input  logic [WORDS*WIDTH-1:0] lat_q,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int            CW       = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OPEN_CYC - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [AW-1:0]    addr_r;
  logic             owner_r;
  logic             last_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] lat_d_r;
  logic [WORDS-1:0] lat_en_r;
  logic [WORDS-1:0] dec_s;
  logic             done0_r;
  logic             done1_r;
  logic             err_r;
  logic             busy_r;
  logic             win1_s;
  logic             grant_s;
  logic             addr_oor_s;

  // Arbitration: a lone request wins; on a tie the requester not served last wins.
  always_comb begin
    win1_s  = req1 & (~req0 | ~last_r);
    gnt0    = (state_r == ST_IDLE) & req0 & ~win1_s;
    gnt1    = (state_r == ST_IDLE) & req1 & win1_s;
    grant_s = gnt0 | gnt1;
  end

  // Word decode of the captured address; out-of-range addresses decode to no word.
  always_comb begin
    dec_s      = '0;
    addr_oor_s = (32'(addr_r) >= 32'(WORDS));
    for (int k = 0; k < WORDS; k++) begin
      dec_s[k] = (32'(addr_r) == 32'(k));
    end
  end

  // Next-state logic for the setup/open/hold write sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  state_nx_s = grant_s ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_nx_s = ST_OPEN;
      ST_OPEN:  state_nx_s = (cnt_r == CNT_LAST) ? ST_HOLD : ST_OPEN;
      ST_HOLD:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Sequencer state and registered latch-side outputs, decoded from next state
  // so lat_en and lat_d only ever change on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      addr_r   <= '0;
      owner_r  <= 1'b0;
      last_r   <= 1'b1;
      cnt_r    <= '0;
      lat_d_r  <= '0;
      lat_en_r <= '0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      if (grant_s) begin
        addr_r  <= win1_s ? addr1 : addr0;
        lat_d_r <= win1_s ? data1 : data0;
        owner_r <= win1_s;
        last_r  <= win1_s;
      end
      cnt_r    <= (state_r == ST_OPEN) ? cnt_r + CW'(1) : '0;
      lat_en_r <= (state_nx_s == ST_OPEN) ? dec_s : '0;
      done0_r  <= (state_nx_s == ST_HOLD) & ~owner_r;
      done1_r  <= (state_nx_s == ST_HOLD) & owner_r;
      err_r    <= (state_nx_s == ST_HOLD) & addr_oor_s;
    end
  end

  // Readback mux; unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < WORDS; k++) begin
      rd_data = (32'(rd_addr) == 32'(k)) ? lat_q[k*WIDTH +: WIDTH] : rd_data;
    end
  end

  assign lat_d  = lat_d_r;
  assign lat_en = lat_en_r;
  assign done0  = done0_r;
  assign done1  = done1_r;
  assign err    = err_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_c_dlatch_bank_ctrl.sv
// Bench for c_dlatch_bank_ctrl: default instance driven by a timing scoreboard,
// plus a WORDS=3 / OPEN_CYC=3 instance for long-open and out-of-range writes.
module tb_c_dlatch_bank_ctrl;

  logic       clk;
  logic       rst;
  int         checks;
  int         failures;
  int         cyc;

  // instance a: defaults (WIDTH=2, WORDS=4, OPEN_CYC=1)
  logic       req0_a, req1_a, gnt0_a, gnt1_a, done0_a, done1_a, err_a, busy_a;
  logic [1:0] addr0_a, addr1_a, data0_a, data1_a, lat_d_a, rd_addr_a, rd_data_a;
  logic [3:0] lat_en_a;
  logic [7:0] lat_q_a;
  logic [1:0] lq_a [4];

  // instance b: WORDS=3, OPEN_CYC=3
  logic       req0_b, req1_b, gnt0_b, gnt1_b, done0_b, done1_b, err_b, busy_b;
  logic [1:0] addr0_b, addr1_b, data0_b, data1_b, lat_d_b, rd_addr_b, rd_data_b;
  logic [2:0] lat_en_b;
  logic [5:0] lat_q_b;
  logic [1:0] lq_b [3];

  typedef struct {
    int         g;
    logic       owner;
    logic [1:0] addr;
    logic [1:0] data;
  } txn_t;

  txn_t       q_a [$];
  logic       m_last_a;
  logic [1:0] m_latd_a;

  c_dlatch_bank_ctrl #(.WIDTH(2), .WORDS(4), .AW(2), .OPEN_CYC(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0_a), .addr0(addr0_a), .data0(data0_a), .gnt0(gnt0_a), .done0(done0_a),
    .req1(req1_a), .addr1(addr1_a), .data1(data1_a), .gnt1(gnt1_a), .done1(done1_a),
    .err(err_a), .busy(busy_a), .lat_d(lat_d_a), .lat_en(lat_en_a), .lat_q(lat_q_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a)
  );

  c_dlatch_bank_ctrl #(.WIDTH(2), .WORDS(3), .AW(2), .OPEN_CYC(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .addr0(addr0_b), .data0(data0_b), .gnt0(gnt0_b), .done0(done0_b),
    .req1(req1_b), .addr1(addr1_b), .data1(data1_b), .gnt1(gnt1_b), .done1(done1_b),
    .err(err_b), .busy(busy_b), .lat_d(lat_d_b), .lat_en(lat_en_b), .lat_q(lat_q_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b)
  );

  // Behavioural latch banks: transparent while the word's enable is high.
  always_latch begin
    for (int k = 0; k < 4; k++) if (lat_en_a[k]) lq_a[k] <= lat_d_a;
  end
  always_latch begin
    for (int k = 0; k < 3; k++) if (lat_en_b[k]) lq_b[k] <= lat_d_b;
  end
  assign lat_q_a = {lq_a[3], lq_a[2], lq_a[1], lq_a[0]};
  assign lat_q_b = {lq_b[2], lq_b[1], lq_b[0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #2;
  endtask

  // Grant model plus per-cycle expectations derived from the in-flight transaction.
  task automatic check_a();
    txn_t       t;
    logic       w1, eg0, eg1, ebusy, ed0, ed1;
    logic [3:0] een;
    w1  = req1_a && (!req0_a || !m_last_a);
    eg0 = (q_a.size() == 0) && req0_a && !w1;
    eg1 = (q_a.size() == 0) && req1_a && w1;
    chk("gnt0_a", 8'(gnt0_a), 8'(eg0));
    chk("gnt1_a", 8'(gnt1_a), 8'(eg1));
    if (eg0 || eg1) begin
      t.g = cyc; t.owner = w1;
      t.addr = w1 ? addr1_a : addr0_a;
      t.data = w1 ? data1_a : data0_a;
      q_a.push_back(t);
      m_last_a = w1;
    end
    ebusy = 1'b0; een = 4'b0000; ed0 = 1'b0; ed1 = 1'b0;
    if (q_a.size() > 0) begin
      t = q_a[0];
      if (cyc == t.g + 1) m_latd_a = t.data;
      if (cyc >= t.g + 1 && cyc <= t.g + 3) ebusy = 1'b1;
      if (cyc == t.g + 2) een = 4'b0001 << t.addr;
      if (cyc == t.g + 3) begin
        ed0 = !t.owner; ed1 = t.owner;
        void'(q_a.pop_front());
      end
    end
    chk("busy_a",   8'(busy_a),   8'(ebusy));
    chk("lat_en_a", 8'(lat_en_a), 8'(een));
    chk("lat_d_a",  8'(lat_d_a),  8'(m_latd_a));
    chk("done0_a",  8'(done0_a),  8'(ed0));
    chk("done1_a",  8'(done1_a),  8'(ed1));
    chk("err_a",    8'(err_a),    8'h00);
  endtask

  task automatic step_a(input logic r0, input logic [1:0] a0, input logic [1:0] d0,
                        input logic r1, input logic [1:0] a1, input logic [1:0] d1);
    tick();
    req0_a = r0; addr0_a = a0; data0_a = d0;
    req1_a = r1; addr1_a = a1; data1_a = d1;
    #1;
    check_a();
  endtask

  task automatic model_reset();
    q_a.delete();
    m_last_a = 1'b1;
    m_latd_a = 2'b00;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1;
    req0_a = 1'b0; req1_a = 1'b0; addr0_a = 2'd0; addr1_a = 2'd0;
    data0_a = 2'd0; data1_a = 2'd0; rd_addr_a = 2'd0;
    req0_b = 1'b0; req1_b = 1'b0; addr0_b = 2'd0; addr1_b = 2'd0;
    data0_b = 2'd0; data1_b = 2'd0; rd_addr_b = 2'd0;
    model_reset();

    // reset values
    #12;
    chk("rst_busy",   8'(busy_a),   8'h00);
    chk("rst_lat_en", 8'(lat_en_a), 8'h00);
    chk("rst_lat_d",  8'(lat_d_a),  8'h00);
    chk("rst_done",   8'({done1_a, done0_a, err_a}), 8'h00);
    chk("rst_busy_b", 8'(busy_b),   8'h00);
    tick();
    rst = 1'b0;

    // tie after reset: requester 0 first, then strict alternation every 4 cycles
    for (int i = 0; i < 16; i++) begin
      step_a(1'b1, 2'd0, 2'b01, 1'b1, 2'd3, 2'b10);
      if (i % 4 == 0) chk("tie_order", 8'({gnt1_a, gnt0_a}), (i % 8 == 0) ? 8'h01 : 8'h02);
    end
    for (int i = 0; i < 2; i++) step_a(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);

    // single write with data changing after the grant
    tick(); rst = 1'b1; #1; model_reset();
    tick(); rst = 1'b0;
    step_a(1'b1, 2'd2, 2'b10, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) step_a(1'b0, 2'd2, 2'b01, 1'b0, 2'd0, 2'd0);
    chk("stable_lat_d", 8'(lat_d_a), 8'h02);
    rd_addr_a = 2'd2; #1;
    chk("rd_word2", 8'(rd_data_a), 8'h02);

    // async reset while the enable is open
    step_a(1'b1, 2'd1, 2'b01, 1'b0, 2'd0, 2'd0);
    step_a(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    step_a(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    rst = 1'b1; #1;
    chk("mid_rst_lat_en", 8'(lat_en_a), 8'h00);
    chk("mid_rst_busy",   8'(busy_a),   8'h00);
    model_reset();
    tick();
    rst = 1'b0;
    req1_a = 1'b1; addr1_a = 2'd0; data1_a = 2'b11; #1;
    chk("post_rst_gnt1", 8'(gnt1_a), 8'h01);
    check_a();
    for (int i = 0; i < 4; i++) step_a(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    rd_addr_a = 2'd1; #1;
    chk("rd_abandoned_word", 8'(rd_data_a), 8'h01);
    rd_addr_a = 2'd0; #1;
    chk("rd_word0", 8'(rd_data_a), 8'h03);

    // instance b: three-cycle open window, in-range write
    for (int k = 0; k < 7; k++) begin
      step_a(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
      req0_b = (k == 0); addr0_b = 2'd1; data0_b = 2'b11; #1;
      if (k == 0) chk("gnt0_b", 8'(gnt0_b), 8'h01);
      chk("lat_en_b", 8'(lat_en_b), (k >= 2 && k <= 4) ? 8'h02 : 8'h00);
      chk("done0_b",  8'(done0_b),  8'(k == 5));
      chk("busy_b",   8'(busy_b),   8'(k >= 1 && k <= 5));
      chk("err_b",    8'(err_b),    8'h00);
    end
    rd_addr_b = 2'd1; #1;
    chk("rd_b_word1", 8'(rd_data_b), 8'h03);

    // instance b: out-of-range address never opens a word and flags err with done
    for (int k = 0; k < 7; k++) begin
      step_a(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
      req1_b = (k == 0); addr1_b = 2'd3; data1_b = 2'b01; #1;
      if (k == 0) chk("gnt1_b", 8'(gnt1_b), 8'h01);
      chk("oor_lat_en_b", 8'(lat_en_b), 8'h00);
      chk("oor_done1_b",  8'(done1_b),  8'(k == 5));
      chk("oor_err_b",    8'(err_b),    8'(k == 5));
    end
    rd_addr_b = 2'd3; #1;
    chk("rd_b_oor", 8'(rd_data_b), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
